at_response_parser: RTL and testbench

AT_RESPONSE_PARSER -- requirements
Module: at_response_parser

---
 rtl/at_response_parser_if.sv | 10 +
 rtl/at_response_parser.sv | 98 +++++++++
 tb/tb_at_response_parser.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/at_response_parser_if.sv
// at_response_parser_if: UART byte stream into the parser and the parser's receive FIFO write port.
interface at_response_parser_if;
    logic [7:0] rx_data;
    logic rx_data_valid;
    logic fifo_full;
    logic fifo_wr_en;
    logic [7:0] fifo_din;
    modport master(output rx_data, rx_data_valid, fifo_full, input fifo_wr_en, fifo_din);
    modport slave(input rx_data, rx_data_valid, fifo_full, output fifo_wr_en, fifo_din);
endinterface

// File: rtl/at_response_parser.sv
// at_response_parser: captures one CR LF terminated AT response line into a FIFO and classifies it as OK / ERROR.
module at_response_parser #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic arm,
    at_response_parser_if.slave bus,
    output logic line_done,
    output logic resp_ok,
    output logic resp_error,
    output logic timeout,
    output logic overflow,
    output logic [7:0] byte_count,
    output logic [2:0] state
);
    typedef enum logic [2:0] {IDLE = 3'd0, WAIT_BYTE = 3'd1, GOT_CR = 3'd2, DONE = 3'd3, TIMEOUT = 3'd4} state_t;
    localparam logic [39:0] ERROR_TEXT = "ERROR";
    localparam logic [15:0] OK_TEXT = "OK";
    state_t state_q, state_d;
    logic [23:0] timer;
    logic ok_match, err_match, stray_cr;
    logic active, take, is_cr, is_lf, ends_line, content, expired;
    logic [7:0] err_char, ok_char;
    assign active = state_q == WAIT_BYTE || state_q == GOT_CR;
    assign take = active && arm && bus.rx_data_valid;
    assign is_cr = bus.rx_data == 8'h0D;
    assign is_lf = bus.rx_data == 8'h0A;
    assign ends_line = take && state_q == GOT_CR && is_lf;
    assign content = take && !is_cr && !ends_line;
    assign expired = active && arm && !bus.rx_data_valid && timer == TIMEOUT_CYCLES - 24'd1;
    assign err_char = 8'(ERROR_TEXT >> (8 * (3'd4 - byte_count[2:0])));
    assign ok_char = byte_count[0] ? OK_TEXT[7:0] : OK_TEXT[15:8];
    assign state = state_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: state_d = arm ? WAIT_BYTE : IDLE;
            WAIT_BYTE, GOT_CR: state_d = !arm ? IDLE : expired ? TIMEOUT : !take ? state_q :
                                         is_cr ? GOT_CR : ends_line ? DONE : WAIT_BYTE;
            DONE: state_d = arm ? DONE : IDLE;
            TIMEOUT: state_d = arm ? TIMEOUT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din <= 8'd0;
            line_done <= 1'b0;
            resp_ok <= 1'b0;
            resp_error <= 1'b0;
            timeout <= 1'b0;
            overflow <= 1'b0;
            byte_count <= 8'd0;
            timer <= 24'd0;
            ok_match <= 1'b0;
            err_match <= 1'b0;
            stray_cr <= 1'b0;
        end else begin
            bus.fifo_wr_en <= take && !bus.fifo_full;
            if (take && !bus.fifo_full) bus.fifo_din <= bus.rx_data;
            line_done <= ends_line;
            if (state_q == IDLE && arm) begin
                resp_ok <= 1'b0;
                resp_error <= 1'b0;
                timeout <= 1'b0;
                overflow <= 1'b0;
                byte_count <= 8'd0;
                timer <= 24'd0;
                ok_match <= 1'b1;
                err_match <= 1'b1;
                stray_cr <= 1'b0;
            end else begin
                if (active) timer <= take ? 24'd0 : timer + 24'd1;
                if (take && bus.fifo_full) overflow <= 1'b1;
                // a CR not followed by the terminating LF means the line is not exactly "OK"
                if (take && state_q == GOT_CR && !is_lf) stray_cr <= 1'b1;
                if (content) begin
                    if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
                    if (byte_count < 8'd5 && bus.rx_data != err_char) err_match <= 1'b0;
                    if (byte_count < 8'd2 && bus.rx_data != ok_char) ok_match <= 1'b0;
                end
                if (ends_line) begin
                    resp_ok <= ok_match && byte_count == 8'd2 && !stray_cr;
                    resp_error <= err_match && byte_count >= 8'd5;
                end
                if (expired) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_at_response_parser.sv
// tb_at_response_parser: randomized and directed lines against a line-level model; FIFO writes and line results go through a scoreboard.
module tb_at_response_parser;
    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic ok; logic err; logic [7:0] cnt; } line_t;
    logic clock = 1'b0, reset = 1'b1, arm = 1'b0;
    logic line_done, resp_ok, resp_error, timeout, overflow;
    logic [7:0] byte_count;
    logic [2:0] state;
    int n_checks = 0, n_fail = 0, cyc = 0;
    wr_t exp_wr[$];
    line_t exp_line[$];

    at_response_parser_if bus();
    at_response_parser #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clock(clock), .reset(reset), .arm(arm), .bus(bus),
        .line_done(line_done), .resp_ok(resp_ok), .resp_error(resp_error), .timeout(timeout),
        .overflow(overflow), .byte_count(byte_count), .state(state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (bus.fifo_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) check("unexpected_write", 32'(exp_wr.size()), 1);
            else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_data", {24'd0, bus.fifo_din}, {24'd0, w.data});
                check("wr_cycle", cyc, w.cyc);
            end
        end
        if (line_done === 1'b1) begin
            if (exp_line.size() == 0) check("unexpected_line_done", 32'(exp_line.size()), 1);
            else begin
                line_t e;
                e = exp_line.pop_front();
                check("resp_ok", resp_ok, e.ok);
                check("resp_error", resp_error, e.err);
                check("byte_count", byte_count, e.cnt);
                check("state_at_done", state, 3);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic full, input logic live);
        @(negedge clock);
        bus.rx_data = b;
        bus.rx_data_valid = 1'b1;
        bus.fifo_full = full;
        if (live && !full) exp_wr.push_back('{data: b, cyc: cyc + 1});
        @(negedge clock);
        bus.rx_data_valid = 1'b0;
        bus.fifo_full = 1'b0;
    endtask

    function automatic bq_t zeros(input int n);
        bq_t z;
        z = {};
        for (int i = 0; i < n; i++) z.push_back(8'd0);
        return z;
    endfunction

    // b ends with the terminating CR LF and contains no earlier CR LF pair
    task automatic run_line(input bq_t b, input bq_t full);
        line_t e;
        bq_t c;
        logic ov, stray;
        logic [39:0] et;
        et = "ERROR";
        ov = 1'b0;
        stray = 1'b0;
        c = {};
        for (int i = 0; i < b.size() - 2; i++)
            if (b[i] == 8'h0D) stray = 1'b1;
            else c.push_back(b[i]);
        e.cnt = c.size() > 255 ? 8'hFF : 8'(c.size());
        e.ok = c.size() == 2 && c[0] == 8'h4F && c[1] == 8'h4B && !stray;
        e.err = c.size() >= 5 && {c[0], c[1], c[2], c[3], c[4]} == et;
        foreach (full[i]) ov |= full[i][0];
        exp_line.push_back(e);
        @(negedge clock) arm = 1'b1;
        foreach (b[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send_byte(b[i], full[i][0], 1'b1);
        end
        repeat (2) @(negedge clock);
        check("line_done_seen", 32'(exp_line.size()), 0);
        check("writes_drained", 32'(exp_wr.size()), 0);
        check("overflow", overflow, ov);
        check("state_done_held", state, 3);
        send_byte(8'h55, 1'b0, 1'b0);
        check("count_after_done_byte", byte_count, e.cnt);
        arm = 1'b0;
        repeat (2) @(negedge clock);
        check("state_idle", state, 0);
        check("resp_ok_kept", resp_ok, e.ok);
        check("resp_error_kept", resp_error, e.err);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h4F;
            1: return 8'h4B;
            2: return 8'h45;
            3: return 8'h52;
            4: return 8'h0D;
            5: return 8'h0A;
            6: return 8'h3A;
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    task automatic random_lines(input int n);
        bq_t b, f;
        int kind;
        logic [7:0] ch;
        logic [39:0] et;
        et = "ERROR";
        for (int l = 0; l < n; l++) begin
            kind = $urandom_range(0, 3);
            b = {};
            if (kind == 0) b = {8'h4F, 8'h4B};
            else if (kind == 1) for (int i = 0; i < 5; i++) b.push_back(et[8*(4-i) +: 8]);
            else if (kind == 2) b = {8'h45, 8'h52, 8'h52, 8'h4F};
            repeat ($urandom_range(0, 4)) begin
                ch = pick();
                if (ch == 8'h0A && b.size() > 0 && b[b.size()-1] == 8'h0D) ch = 8'h58;
                b.push_back(ch);
            end
            b.push_back(8'h0D);
            b.push_back(8'h0A);
            f = {};
            foreach (b[i]) f.push_back(8'($urandom_range(0, 5) == 0));
            run_line(b, f);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t b, f;
        int t0;
        bus.rx_data = 8'd0;
        bus.rx_data_valid = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", state, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_flags", {line_done, resp_ok, resp_error, timeout, overflow}, 0);
        check("rst_count", byte_count, 0);
        reset = 1'b0;
        send_byte(8'h41, 1'b0, 1'b0);
        check("idle_byte_dropped_state", state, 0);
        check("idle_byte_dropped_count", byte_count, 0);

        run_line({8'h4F, 8'h4B, 8'h0D, 8'h0A}, zeros(4));
        b = {8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h3A, 8'h28, 8'h30, 8'h29, 8'h0D, 8'h0A};
        run_line(b, zeros(11));
        f = zeros(4);
        f[1] = 8'd1;
        run_line({8'h4F, 8'h4B, 8'h0D, 8'h0A}, f);
        run_line({8'h4F, 8'h0D, 8'h0D, 8'h4B, 8'h0D, 8'h0A}, zeros(6));
        b = {};
        for (int i = 0; i < 300; i++) b.push_back(8'h5A);
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        run_line(b, zeros(302));

        // timeout after exactly TIMEOUT_CYCLES idle cycles
        @(negedge clock) arm = 1'b1;
        @(negedge clock);
        t0 = cyc;
        for (int i = 0; i < 200 && state != 3'd4; i++) @(negedge clock);
        check("timeout_latency", cyc - t0, 100);
        check("timeout_flag", timeout, 1);
        check("timeout_state", state, 4);
        arm = 1'b0;
        repeat (2) @(negedge clock);
        check("timeout_idle_state", state, 0);
        check("timeout_kept", timeout, 1);

        // byte on the expiry cycle wins, then abort mid-line
        @(negedge clock) arm = 1'b1;
        @(negedge clock);
        repeat (98) @(negedge clock);
        send_byte(8'h41, 1'b0, 1'b1);
        check("expiry_byte_state", state, 1);
        check("expiry_byte_no_timeout", timeout, 0);
        arm = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_state", state, 0);
        check("abort_writes_drained", 32'(exp_wr.size()), 0);

        // asynchronous reset mid-line
        @(negedge clock) arm = 1'b1;
        send_byte(8'h4F, 1'b0, 1'b1);
        send_byte(8'h4B, 1'b0, 1'b1);
        check("pre_reset_count", byte_count, 2);
        #1 reset = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_count", byte_count, 0);
        check("async_rst_bus", {bus.fifo_wr_en, bus.fifo_din}, 0);
        check("async_rst_flags", {line_done, resp_ok, resp_error, timeout, overflow}, 0);
        @(negedge clock);
        reset = 1'b0;
        arm = 1'b0;
        @(negedge clock);
        check("post_reset_idle", state, 0);
        run_line({8'h4F, 8'h4B, 8'h0D, 8'h0A}, zeros(4));

        random_lines(40);
        check("final_wr_queue", 32'(exp_wr.size()), 0);
        check("final_line_queue", 32'(exp_line.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
